// File: rtl/airlock_pkg.sv
// Shared airlock definitions: state encoding, output bundle and its Moore decode.
package airlock_pkg;

  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    ST_PRESS_IDLE   = 3'd0,
    ST_EVAC_REQ     = 3'd1,
    ST_EVACUATING   = 3'd2,
    ST_EVAC_IDLE    = 3'd3,
    ST_PRESS_REQ    = 3'd4,
    ST_PRESSURIZING = 3'd5,
    ST_FAULT        = 3'd7
  } state_t;

  typedef struct packed {
    logic countdown;
    logic pump_on;
    logic vent_on;
    logic inner_unlock;
    logic outer_unlock;
    logic busy;
    logic fault;
  } outs_t;

  // Outputs depend on state alone; the FSM registers this decode of the next state.
  function automatic outs_t decode_outs(input state_t s);
    outs_t o;
    o = '0;
    case (s)
      ST_PRESS_IDLE:   o.inner_unlock = 1'b1;
      ST_EVAC_REQ: begin
        o.countdown = 1'b1;
        o.vent_on   = 1'b1;
        o.busy      = 1'b1;
      end
      ST_EVACUATING: begin
        o.vent_on = 1'b1;
        o.busy    = 1'b1;
      end
      ST_EVAC_IDLE:    o.outer_unlock = 1'b1;
      ST_PRESS_REQ: begin
        o.countdown = 1'b1;
        o.pump_on   = 1'b1;
        o.busy      = 1'b1;
      end
      ST_PRESSURIZING: begin
        o.pump_on = 1'b1;
        o.busy    = 1'b1;
      end
      ST_FAULT:        o.fault = 1'b1;
      default:         o.fault = 1'b1;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/airlock_timer.sv
// Saturating wait counter guarding the chamber timer; expired holds once the limit is reached.
module airlock_timer
  import airlock_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/airlock_ctrl.sv
// Airlock sequencer: interlocked request handling, timer start pulse, pump/vent and door unlocks.
//
// state        | meaning
// PRESS_IDLE   | chamber at pressure, inner door may open
// EVAC_REQ     | one-cycle countdown pulse, venting starts
// EVACUATING   | venting, waiting for timer completion
// EVAC_IDLE    | chamber evacuated, outer door may open
// PRESS_REQ    | one-cycle countdown pulse, pumping starts
// PRESSURIZING | pumping, waiting for timer completion
// FAULT        | timeout or door breach, latched until reset
module airlock_ctrl
  import airlock_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       req_evac,
  input  logic       req_press,
  input  logic       inner_closed,
  input  logic       outer_closed,
  input  logic       pressurized,
  input  logic       devacuated,
  output logic       countdown,
  output logic       pump_on,
  output logic       vent_on,
  output logic       inner_unlock,
  output logic       outer_unlock,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state_o
);

  state_t state;
  state_t nxt;
  outs_t  outs;
  logic   doors_ok;
  logic   expired;
  logic   tmr_clear;
  logic   tmr_enable;

  assign doors_ok = inner_closed && outer_closed;

  // Completion beats a breach, which beats a timeout, when they coincide.
  always_comb begin
    nxt = state;
    case (state)
      ST_PRESS_IDLE:   if (req_evac && doors_ok) nxt = ST_EVAC_REQ;
      ST_EVAC_REQ:     nxt = ST_EVACUATING;
      ST_EVACUATING: begin
        if (devacuated)     nxt = ST_EVAC_IDLE;
        else if (!doors_ok) nxt = ST_FAULT;
        else if (expired)   nxt = ST_FAULT;
      end
      ST_EVAC_IDLE:    if (req_press && doors_ok) nxt = ST_PRESS_REQ;
      ST_PRESS_REQ:    nxt = ST_PRESSURIZING;
      ST_PRESSURIZING: begin
        if (pressurized)    nxt = ST_PRESS_IDLE;
        else if (!doors_ok) nxt = ST_FAULT;
        else if (expired)   nxt = ST_FAULT;
      end
      ST_FAULT:        nxt = ST_FAULT;
      default:         nxt = ST_FAULT;
    endcase
  end

  // The counter starts from zero in the request cycle so it reads 7 at a nominal strobe.
  assign tmr_clear  = (nxt == ST_EVAC_REQ) || (nxt == ST_PRESS_REQ);
  assign tmr_enable = (state == ST_EVAC_REQ) || (state == ST_EVACUATING) ||
                      (state == ST_PRESS_REQ) || (state == ST_PRESSURIZING);

  airlock_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (expired)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= ST_PRESS_IDLE;
      outs  <= decode_outs(ST_PRESS_IDLE);
    end else begin
      state <= nxt;
      outs  <= decode_outs(nxt);
    end
  end

  assign countdown    = outs.countdown;
  assign pump_on      = outs.pump_on;
  assign vent_on      = outs.vent_on;
  assign inner_unlock = outs.inner_unlock;
  assign outer_unlock = outs.outer_unlock;
  assign busy         = outs.busy;
  assign fault        = outs.fault;
  assign state_o      = state;

endmodule

// File: tb/tb_airlock_ctrl.sv
// Directed bench for airlock_ctrl; expected output vectors are hand-written per state.
module tb_airlock_ctrl;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       req_evac = 1'b0;
  logic       req_press = 1'b0;
  logic       inner_closed = 1'b1;
  logic       outer_closed = 1'b1;
  logic       pressurized = 1'b0;
  logic       devacuated = 1'b0;
  logic       countdown, pump_on, vent_on, inner_unlock, outer_unlock, busy, fault;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  // {state_o, countdown, pump_on, vent_on, inner_unlock, outer_unlock, busy, fault}
  localparam logic [9:0] E_PIDLE = {3'd0, 7'b0001000};
  localparam logic [9:0] E_EREQ  = {3'd1, 7'b1010010};
  localparam logic [9:0] E_EVAC  = {3'd2, 7'b0010010};
  localparam logic [9:0] E_EIDLE = {3'd3, 7'b0000100};
  localparam logic [9:0] E_PREQ  = {3'd4, 7'b1100010};
  localparam logic [9:0] E_PRESS = {3'd5, 7'b0100010};
  localparam logic [9:0] E_FLT   = {3'd7, 7'b0000001};

  logic [9:0] obs;
  assign obs = {state_o, countdown, pump_on, vent_on, inner_unlock, outer_unlock, busy, fault};

  airlock_ctrl dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .req_evac     (req_evac),
    .req_press    (req_press),
    .inner_closed (inner_closed),
    .outer_closed (outer_closed),
    .pressurized  (pressurized),
    .devacuated   (devacuated),
    .countdown    (countdown),
    .pump_on      (pump_on),
    .vent_on      (vent_on),
    .inner_unlock (inner_unlock),
    .outer_unlock (outer_unlock),
    .busy         (busy),
    .fault        (fault),
    .state_o      (state_o)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    Reset = 1'b0;
    #1;
    total++;
    if (obs !== E_PIDLE) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", obs, E_PIDLE);
    end
    #20;
    Reset = 1'b1;
    step();
    total++;
    if (obs !== E_PIDLE) begin
      bad++;
      $display("FAIL reset_release got=%b exp=%b", obs, E_PIDLE);
    end
  endtask

  // req_evac in cycle 0, countdown in cycle 1, strobe in cycle 8, outer unlock in cycle 9.
  task automatic test_evac_flow();
    req_evac = 1'b1;
    step();
    req_evac = 1'b0;
    total++;
    if (obs !== E_EREQ) begin
      bad++;
      $display("FAIL evac_c1 got=%b exp=%b", obs, E_EREQ);
    end
    for (int c = 2; c <= 8; c++) begin
      step();
      total++;
      if (obs !== E_EVAC) begin
        bad++;
        $display("FAIL evac_wait_c%0d got=%b exp=%b", c, obs, E_EVAC);
      end
    end
    devacuated = 1'b1;
    step();
    devacuated = 1'b0;
    total++;
    if (obs !== E_EIDLE) begin
      bad++;
      $display("FAIL evac_done_c9 got=%b exp=%b", obs, E_EIDLE);
    end
  endtask

  task automatic test_press_flow();
    req_evac    = 1'b1;
    pressurized = 1'b1;
    step();
    req_evac    = 1'b0;
    pressurized = 1'b0;
    total++;
    if (obs !== E_EIDLE) begin
      bad++;
      $display("FAIL eidle_ignore got=%b exp=%b", obs, E_EIDLE);
    end
    req_press = 1'b1;
    step();
    req_press = 1'b0;
    total++;
    if (obs !== E_PREQ) begin
      bad++;
      $display("FAIL press_c1 got=%b exp=%b", obs, E_PREQ);
    end
    for (int c = 2; c <= 8; c++) begin
      step();
      total++;
      if (obs !== E_PRESS) begin
        bad++;
        $display("FAIL press_wait_c%0d got=%b exp=%b", c, obs, E_PRESS);
      end
    end
    pressurized = 1'b1;
    step();
    pressurized = 1'b0;
    total++;
    if (obs !== E_PIDLE) begin
      bad++;
      $display("FAIL press_done got=%b exp=%b", obs, E_PIDLE);
    end
    req_press  = 1'b1;
    devacuated = 1'b1;
    step();
    req_press  = 1'b0;
    devacuated = 1'b0;
    total++;
    if (obs !== E_PIDLE) begin
      bad++;
      $display("FAIL pidle_ignore got=%b exp=%b", obs, E_PIDLE);
    end
  endtask

  task automatic test_door_open_ignored();
    outer_closed = 1'b0;
    req_evac     = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (obs !== E_PIDLE) begin
        bad++;
        $display("FAIL door_open_req_c%0d got=%b exp=%b", c, obs, E_PIDLE);
      end
    end
    req_evac     = 1'b0;
    outer_closed = 1'b1;
  endtask

  task automatic test_breach();
    req_evac = 1'b1;
    step();
    req_evac = 1'b0;
    step();
    step();
    total++;
    if (obs !== E_EVAC) begin
      bad++;
      $display("FAIL breach_pre got=%b exp=%b", obs, E_EVAC);
    end
    inner_closed = 1'b0;
    step();
    inner_closed = 1'b1;
    total++;
    if (obs !== E_FLT) begin
      bad++;
      $display("FAIL breach_fault got=%b exp=%b", obs, E_FLT);
    end
    req_evac   = 1'b1;
    req_press  = 1'b1;
    devacuated = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (obs !== E_FLT) begin
        bad++;
        $display("FAIL fault_hold_c%0d got=%b exp=%b", c, obs, E_FLT);
      end
    end
    req_evac   = 1'b0;
    req_press  = 1'b0;
    devacuated = 1'b0;
    do_reset();
    step();
    total++;
    if (obs !== E_PIDLE) begin
      bad++;
      $display("FAIL fault_cleared got=%b exp=%b", obs, E_PIDLE);
    end
  endtask

  // Counter reads c-1 in cycle c, so it hits 16 in cycle 17 and the fault lands in cycle 18.
  task automatic test_timeout();
    req_evac = 1'b1;
    step();
    req_evac = 1'b0;
    for (int c = 2; c <= 17; c++) begin
      step();
      total++;
      if (obs !== E_EVAC) begin
        bad++;
        $display("FAIL timeout_wait_c%0d got=%b exp=%b", c, obs, E_EVAC);
      end
    end
    step();
    total++;
    if (obs !== E_FLT) begin
      bad++;
      $display("FAIL timeout_fault got=%b exp=%b", obs, E_FLT);
    end
    do_reset();
    step();
    req_evac = 1'b1;
    step();
    req_evac = 1'b0;
    for (int c = 2; c <= 17; c++) step();
    total++;
    if (obs !== E_EVAC) begin
      bad++;
      $display("FAIL boundary_pre got=%b exp=%b", obs, E_EVAC);
    end
    devacuated = 1'b1;
    step();
    devacuated = 1'b0;
    total++;
    if (obs !== E_EIDLE) begin
      bad++;
      $display("FAIL boundary_strobe got=%b exp=%b", obs, E_EIDLE);
    end
    do_reset();
    step();
  endtask

  task automatic test_reset_mid();
    req_evac = 1'b1;
    step();
    req_evac = 1'b0;
    step();
    step();
    total++;
    if (obs !== E_EVAC) begin
      bad++;
      $display("FAIL midreset_pre got=%b exp=%b", obs, E_EVAC);
    end
    #2;
    Reset = 1'b0;
    #1;
    total++;
    if (obs !== E_PIDLE) begin
      bad++;
      $display("FAIL midreset_async got=%b exp=%b", obs, E_PIDLE);
    end
    step();
    #2;
    Reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (obs !== E_PIDLE) begin
        bad++;
        $display("FAIL midreset_after_c%0d got=%b exp=%b", c, obs, E_PIDLE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_evac_flow();
    test_press_flow();
    test_door_open_ignored();
    test_breach();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
